mem_write_monitor: RTL and testbench

- Synthesizable responder-side checker on the core's data-memory write port (write enable, address, write data).
- Watches writes from the processor and delivers a pass/fail/timeout verdict in hardware. The same program-completion check can then run on the board as well as in simulation.
- Sits beside the data memory in the top level and taps the same write signals the memory consumes.
- Exposes write count and last-write capture for debug.

---
 rtl/mem_write_monitor.sv | 95 +++++++++
 tb/tb_mem_write_monitor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_write_monitor.sv
// Responder-side checker on the data-memory write port: arms on start, watches
// writes, and latches a pass/fail/timeout verdict until reset.
module mem_write_monitor #(
  parameter int unsigned             N           = 32,
  parameter int unsigned             ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]       TARGET_ADDR = ADDR_W'(100),
  parameter logic [N-1:0]            TARGET_DATA = N'(7),
  parameter logic [ADDR_W-1:0]       ALLOW_ADDR  = ADDR_W'(96),
  parameter int unsigned             TIMEOUT     = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [N-1:0]      mem_wdata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [15:0]       write_count,
  output logic [ADDR_W-1:0] last_addr,
  output logic [N-1:0]      last_data
);

  localparam int unsigned   CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [15:0]       wcount_nxt;
  logic [ADDR_W-1:0] laddr_nxt;
  logic [N-1:0]      ldata_nxt;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    wcount_nxt = write_count;
    laddr_nxt  = last_addr;
    ldata_nxt  = last_data;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        cnt_nxt = cnt + 1'b1;
        if (mem_we) begin
          if (write_count != 16'hFFFF) wcount_nxt = write_count + 16'd1;
          laddr_nxt = mem_addr;
          ldata_nxt = mem_wdata;
          if (mem_addr == TARGET_ADDR)
            state_nxt = (mem_wdata == TARGET_DATA) ? S_PASS : S_FAIL;
          else if (mem_addr != ALLOW_ADDR)
            state_nxt = S_FAIL;
        end
        // A tolerated write is not a verdict, so the timeout still applies to it.
        if (state_nxt == S_RUN && cnt == CNT_LAST) state_nxt = S_TIMEOUT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      write_count <= '0;
      last_addr   <= '0;
      last_data   <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      write_count <= wcount_nxt;
      last_addr   <= laddr_nxt;
      last_data   <= ldata_nxt;
    end
  end

  assign pass    = (state == S_PASS);
  assign fail    = (state == S_FAIL);
  assign timeout = (state == S_TIMEOUT);
  assign done    = pass | fail | timeout;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Scoreboard bench for mem_write_monitor: directed writes push expected results,
// a negedge monitor pops and compares against the selected instance.
module tb_mem_write_monitor;

  logic        clk;
  logic        rst_a, rst_b, start, we;
  logic [31:0] addr, wdata;

  logic        done_a, pass_a, fail_a, to_a;
  logic [15:0] cnt_a;
  logic [31:0] la_a, ld_a;
  logic        done_b, pass_b, fail_b, to_b;
  logic [15:0] cnt_b;
  logic [31:0] la_b, ld_b;

  mem_write_monitor #(.TIMEOUT(16)) dut_a (
    .clk(clk), .reset(rst_a), .start(start), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .done(done_a), .pass(pass_a), .fail(fail_a),
    .timeout(to_a), .write_count(cnt_a), .last_addr(la_a), .last_data(ld_a)
  );

  mem_write_monitor #(.TIMEOUT(80000)) dut_b (
    .clk(clk), .reset(rst_b), .start(start), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .done(done_b), .pass(pass_b), .fail(fail_b),
    .timeout(to_b), .write_count(cnt_b), .last_addr(la_b), .last_data(ld_b)
  );

  typedef struct {
    string       name;
    bit          sel;
    logic [3:0]  flags;   // {done, pass, fail, timeout}
    logic [15:0] cnt;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        r;
      logic [3:0]  gf;
      logic [15:0] gc;
      logic [31:0] ga, gd;
      r  = q.pop_front();
      gf = r.sel ? {done_b, pass_b, fail_b, to_b} : {done_a, pass_a, fail_a, to_a};
      gc = r.sel ? cnt_b : cnt_a;
      ga = r.sel ? la_b : la_a;
      gd = r.sel ? ld_b : ld_a;
      tests++;
      if (gf !== r.flags || gc !== r.cnt || ga !== r.addr || gd !== r.data) begin
        fails++;
        $display("FAIL %s: got flags=%b cnt=%h addr=%h data=%h, want flags=%b cnt=%h addr=%h data=%h",
                 r.name, gf, gc, ga, gd, r.flags, r.cnt, r.addr, r.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string nm, input bit sel, input logic [3:0] f,
                           input logic [15:0] c, input logic [31:0] a, input logic [31:0] d);
    exp_t r;
    r.name = nm; r.sel = sel; r.flags = f; r.cnt = c; r.addr = a; r.data = d;
    q.push_back(r);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; addr = 'x; wdata = 'x;
  endtask

  task automatic rearm_a();
    rst_a = 1'b0; tick();
    rst_a = 1'b1; start = 1'b1; tick();
    start = 1'b0;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; start = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    // 1: reset, then allowed writes and the passing write
    tick(); tick();
    expect_st("reset_a", 0, 4'b0000, 16'd0, 32'd0, 32'd0);
    rst_a = 1'b1; start = 1'b1; tick(); start = 1'b0;
    expect_st("armed", 0, 4'b0000, 16'd0, 32'd0, 32'd0);
    wr(96, 5);  expect_st("t1_w1", 0, 4'b0000, 16'd1, 32'd96, 32'd5);
    wr(96, 9);  expect_st("t1_w2", 0, 4'b0000, 16'd2, 32'd96, 32'd9);
    wr(100, 7); expect_st("t1_pass", 0, 4'b1100, 16'd3, 32'd100, 32'd7);
    tick();     expect_st("t1_hold", 0, 4'b1100, 16'd3, 32'd100, 32'd7);

    // 2: wrong data at target, then terminal hold
    rst_a = 1'b0; tick();
    expect_st("t2_reset_from_pass", 0, 4'b0000, 16'd0, 32'd0, 32'd0);
    rst_a = 1'b1; start = 1'b1; tick(); start = 1'b0;
    wr(100, 8); expect_st("t2_fail", 0, 4'b1010, 16'd1, 32'd100, 32'd8);
    wr(100, 7); expect_st("t2_frozen", 0, 4'b1010, 16'd1, 32'd100, 32'd8);

    // 3: allowed write keeps RUN, stray address fails
    rearm_a();
    wr(96, 32'hDEADBEEF); expect_st("t3_allow", 0, 4'b0000, 16'd1, 32'd96, 32'hDEADBEEF);
    wr(64, 7);            expect_st("t3_fail", 0, 4'b1010, 16'd2, 32'd64, 32'd7);

    // 4a: timeout exactly 16 edges after start; start mid-run ignored
    rearm_a();
    for (int k = 1; k <= 16; k++) begin
      start = (k == 5);
      tick();
      if (k == 15) expect_st("t4_before_to", 0, 4'b0000, 16'd0, 32'd0, 32'd0);
      if (k == 16) expect_st("t4_timeout", 0, 4'b1001, 16'd0, 32'd0, 32'd0);
    end
    start = 1'b0;

    // 4b: passing write on the last counter value wins over timeout
    rearm_a();
    repeat (15) tick();
    expect_st("t4b_pre", 0, 4'b0000, 16'd0, 32'd0, 32'd0);
    wr(100, 7); expect_st("t4b_pass", 0, 4'b1100, 16'd1, 32'd100, 32'd7);

    // 4c: a tolerated write on the last counter value still times out
    rearm_a();
    repeat (15) tick();
    wr(96, 1); expect_st("t4c_allow_to", 0, 4'b1001, 16'd1, 32'd96, 32'd1);

    // 5: writes in IDLE ignored; reset mid-RUN clears everything
    rst_a = 1'b0; tick(); rst_a = 1'b1;
    wr(100, 7); expect_st("t5_idle_w1", 0, 4'b0000, 16'd0, 32'd0, 32'd0);
    wr(64, 1);  expect_st("t5_idle_w2", 0, 4'b0000, 16'd0, 32'd0, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    wr(96, 1); wr(96, 2);
    expect_st("t5_two_allowed", 0, 4'b0000, 16'd2, 32'd96, 32'd2);
    rst_a = 1'b0; wr(96, 3);
    expect_st("t5_mid_reset", 0, 4'b0000, 16'd0, 32'd0, 32'd0);
    rst_a = 1'b1;
    wr(100, 7); expect_st("t5_idle_after", 0, 4'b0000, 16'd0, 32'd0, 32'd0);
    rst_a = 1'b0;

    // 6: write_count saturation on the long-timeout instance
    tick(); expect_st("t6_reset_b", 1, 4'b0000, 16'd0, 32'd0, 32'd0);
    rst_b = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      we = 1'b1; addr = 32'd96; wdata = 32'(i);
      tick();
      if (i == 65533) expect_st("t6_fffe", 1, 4'b0000, 16'hFFFE, 32'd96, 32'd65533);
      if (i == 65534) expect_st("t6_ffff", 1, 4'b0000, 16'hFFFF, 32'd96, 32'd65534);
    end
    we = 1'b0;
    expect_st("t6_saturated", 1, 4'b0000, 16'hFFFF, 32'd96, 32'd69999);
    tick(); expect_st("t6_hold", 1, 4'b0000, 16'hFFFF, 32'd96, 32'd69999);

    for (int w = 0; w < 8 && q.size() > 0; w++) tick();
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
